// File: rtl/icache_pkg.sv
// Shared types and geometry helpers for the direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int DEF_LINE_WORDS = 4;
  localparam int DEF_SETS       = 16;

  function automatic int off_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int line_words, input int sets);
    return 30 - off_w(line_words) - idx_w(sets);
  endfunction

  // Bit positions of the address fields within a [31:2] word address.
  function automatic int off_lsb();
    return 2;
  endfunction

  function automatic int idx_lsb(input int ow);
    return off_lsb() + ow;
  endfunction

  function automatic int tag_lsb(input int ow, input int iw);
    return off_lsb() + ow + iw;
  endfunction

endpackage

// File: rtl/icache_tag_ram.sv
// Tag and valid arrays: combinational hit compare, one-edge clear of every valid bit.
module icache_tag_ram
  import icache_pkg::*;
#(
  parameter int SETS  = DEF_SETS,
  parameter int IDX_W = idx_w(DEF_SETS),
  parameter int TAG_W = tag_w(DEF_LINE_WORDS, DEF_SETS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] lk_idx,
  input  logic [TAG_W-1:0] lk_tag,
  output logic             hit,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             wr_set_valid,
  input  logic             clr_all
);

  logic [TAG_W-1:0] tags [SETS];
  logic [SETS-1:0]  valid;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_idx] <= wr_tag;
    end
  end

  // A clear on the same edge as an install wins, so a flushed refill never validates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (clr_all) begin
      valid <= '0;
    end else if (wr_en && wr_set_valid) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  assign hit = valid[lk_idx] && (tags[lk_idx] == lk_tag);

endmodule

// File: rtl/icache_refill_ctrl.sv
// Direct-mapped I-cache with whole-line refill over a req/gnt/rvalid port.
// Optional ICACHE_PERF_CNT_EN adds saturating hit/miss counters.
module icache_refill_ctrl
  import icache_pkg::*;
#(
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int SETS       = DEF_SETS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic [31:2] cpu_addr,
  output logic        cpu_stall,
  output logic        cpu_valid,
  output logic [31:0] cpu_inst,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:2] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  localparam int OFF_W   = off_w(LINE_WORDS);
  localparam int IDX_W   = idx_w(SETS);
  localparam int TAG_W   = tag_w(LINE_WORDS, SETS);
  localparam int IDX_LSB = idx_lsb(OFF_W);
  localparam int TAG_LSB = tag_lsb(OFF_W, IDX_W);
  localparam logic [OFF_W:0] LW_CNT    = LINE_WORDS[OFF_W:0];
  localparam logic [OFF_W:0] LAST_WORD = LINE_WORDS[OFF_W:0] - 1'b1;

  state_t state, state_d;

  logic [29-OFF_W:0] line_q;
  logic [OFF_W:0]    req_cnt;
  logic [OFF_W:0]    resp_cnt;
  logic              flush_pend;

  logic [OFF_W-1:0]  lk_off;
  logic [IDX_W-1:0]  lk_idx;
  logic [TAG_W-1:0]  lk_tag;
  logic [IDX_W-1:0]  fill_idx;
  logic [TAG_W-1:0]  fill_tag;

  logic hit;
  logic lookup_hit;
  logic start_refill;
  logic fill_wr;
  logic fill_done;
  logic clr_all;

  logic [31:0] data_mem [SETS*LINE_WORDS];

  assign lk_off   = cpu_addr[OFF_W+1:2];
  assign lk_idx   = cpu_addr[IDX_LSB +: IDX_W];
  assign lk_tag   = cpu_addr[TAG_LSB +: TAG_W];
  assign fill_idx = line_q[IDX_W-1:0];
  assign fill_tag = line_q[IDX_W +: TAG_W];

  // A flush outside REFILL clears at once; inside REFILL it waits for the line to drain.
  assign clr_all = (flush && (state != REFILL)) || (fill_done && (flush_pend || flush));

  icache_tag_ram #(
    .SETS  (SETS),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_tag_ram (
    .clk          (clk),
    .rst_n        (rst_n),
    .lk_idx       (lk_idx),
    .lk_tag       (lk_tag),
    .hit          (hit),
    .wr_en        (fill_done),
    .wr_idx       (fill_idx),
    .wr_tag       (fill_tag),
    .wr_set_valid (!(flush_pend || flush)),
    .clr_all      (clr_all)
  );

  always_comb begin
    state_d      = state;
    lookup_hit   = 1'b0;
    start_refill = 1'b0;
    fill_wr      = 1'b0;
    fill_done    = 1'b0;
    mem_req      = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req) begin
          if (hit) begin
            lookup_hit = 1'b1;
          end else begin
            start_refill = 1'b1;
            state_d      = REFILL;
          end
        end
      end
      REFILL: begin
        mem_req = (req_cnt < LW_CNT);
        if (mem_rvalid) begin
          fill_wr = 1'b1;
          if (resp_cnt == LAST_WORD) begin
            fill_done = 1'b1;
            state_d   = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign cpu_stall = (state != IDLE) || (cpu_req && !hit);
  assign mem_addr  = {line_q, req_cnt[OFF_W-1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_cnt    <= '0;
      resp_cnt   <= '0;
      flush_pend <= 1'b0;
    end else begin
      state <= state_d;
      if (start_refill) begin
        req_cnt  <= '0;
        resp_cnt <= '0;
      end else begin
        if (mem_req && mem_gnt) begin
          req_cnt <= req_cnt + 1'b1;
        end
        if (fill_wr) begin
          resp_cnt <= resp_cnt + 1'b1;
        end
      end
      if (fill_done) begin
        flush_pend <= 1'b0;
      end else if ((state == REFILL) && flush) begin
        flush_pend <= 1'b1;
      end
    end
  end

  // Line base is pure address data; it is only observed while REFILL drives mem_req.
  always_ff @(posedge clk) begin
    if (start_refill) begin
      line_q <= cpu_addr[31:IDX_LSB];
    end
  end

  always_ff @(posedge clk) begin
    if (fill_wr) begin
      data_mem[{fill_idx, resp_cnt[OFF_W-1:0]}] <= mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_valid <= 1'b0;
      cpu_inst  <= '0;
    end else begin
      cpu_valid <= lookup_hit;
      if (lookup_hit) begin
        cpu_inst <= data_mem[{lk_idx, lk_off}];
      end
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (lookup_hit && (hit_cnt != 32'hFFFF_FFFF)) begin
        hit_cnt <= hit_cnt + 32'd1;
      end
      if (start_refill && (miss_cnt != 32'hFFFF_FFFF)) begin
        miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl with a set-level cache model and a zero-wait memory.
module tb_icache_refill_ctrl;

  localparam int LW = 4;
  localparam int NS = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0;
  logic [31:2] cpu_addr = '0;
  logic        cpu_stall;
  logic        cpu_valid;
  logic [31:0] cpu_inst;
  logic        flush = 1'b0;
  logic        mem_req;
  logic [31:2] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  icache_refill_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .cpu_stall  (cpu_stall),
    .cpu_valid  (cpu_valid),
    .cpu_inst   (cpu_inst),
    .flush      (flush),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag_fail(input string name, input logic [31:0] act);
    nvec++;
    nmis++;
    $display("FAIL %s: observed 0x%08h with nothing expected (cycle %0d)", name, act, cyc);
  endtask

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    return {a, 2'b01} ^ 32'h3C00_0000;
  endfunction

  // Memory: grant whenever requested (unless withholding), data one cycle after grant.
  logic [29:0] pend_q[$];
  int gnt_hold = 0;
  bit in_reset = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (mem_req && mem_gnt) pend_q.push_back(mem_addr);
      @(posedge clk);
      #1;
      if (in_reset) pend_q.delete();
      if (pend_q.size() > 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mem_word(pend_q.pop_front());
      end else begin
        mem_rvalid = 1'b0;
        mem_rdata  = 32'hBAD0_BAD0;
      end
      if (mem_req && gnt_hold > 0) begin
        mem_gnt = 1'b0;
        gnt_hold--;
      end else begin
        mem_gnt = mem_req;
      end
    end
  end

  // Model: which line each set holds, plus expected traffic and deliveries.
  int          m_tag [NS];
  bit          m_val [NS];
  logic [29:0] exp_mem[$];
  logic [31:0] exp_word[$];
  int          exp_cyc[$];
  int          tot_hits = 0;
  int          tot_miss = 0;
  int          run_start = 0;
  int          run_first_valid = -1;
  int          run_last_valid = -1;
  int          run_grants = 0;
  int          bp_cycles = 0;

  initial begin
    logic [31:0] w;
    int          c;
    forever begin
      @(negedge clk);
      if (!in_reset) begin
        if (cpu_valid) begin
          if (exp_word.size() == 0) begin
            flag_fail("spurious_cpu_valid", cpu_inst);
          end else begin
            w = exp_word.pop_front();
            c = exp_cyc.pop_front();
            chk("cpu_inst", cpu_inst, w);
            chk("valid_cycle", cyc, c);
            if (run_first_valid < 0) run_first_valid = cyc;
            run_last_valid = cyc;
          end
        end
        if (mem_req) begin
          if (exp_mem.size() == 0) begin
            flag_fail("unexpected_mem_req", {2'b00, mem_addr});
          end else if (mem_gnt) begin
            chk("mem_addr", {2'b00, mem_addr}, {2'b00, exp_mem.pop_front()});
            run_grants++;
          end else begin
            chk("mem_addr_held", {2'b00, mem_addr}, {2'b00, exp_mem[0]});
            bp_cycles++;
          end
        end
      end
    end
  end

  logic [29:0] seq[$];
  int opt_hold = 0;
  bit opt_flush_refill = 1'b0;
  bit opt_flush_idle = 1'b0;

  task automatic model_clear();
    for (int s = 0; s < NS; s++) m_val[s] = 1'b0;
  endtask

  // Present each address in turn; a new one only after the previous was not stalled.
  task automatic run();
    logic [29:0] a;
    int line, set, tg, lat, t;
    bit h;
    run_first_valid = -1;
    run_last_valid  = -1;
    run_grants      = 0;
    bp_cycles       = 0;
    gnt_hold        = opt_hold;
    @(posedge clk);
    #1;
    for (int i = 0; i < seq.size(); i++) begin
      a    = seq[i];
      line = int'(a) / LW;
      set  = line % NS;
      tg   = line / NS;
      h    = m_val[set] && (m_tag[set] == tg);
      lat  = 1;
      cpu_req  = 1'b1;
      cpu_addr = a;
      if (i == 0) begin
        run_start = cyc;
        flush     = opt_flush_idle;
        if (opt_flush_idle) model_clear();
      end
      if (!h) begin
        tot_miss++;
        lat = 8 + opt_hold;
        for (int k = 0; k < LW; k++) exp_mem.push_back(30'(line * LW + k));
        if (i == 0 && opt_flush_refill) begin
          // The flushed line is not kept, so the held address misses once more.
          for (int k = 0; k < LW; k++) exp_mem.push_back(30'(line * LW + k));
          lat += 7;
          tot_miss++;
          model_clear();
        end
        m_val[set] = 1'b1;
        m_tag[set] = tg;
      end
      tot_hits++;
      exp_word.push_back(mem_word(a));
      exp_cyc.push_back(cyc + lat);
      t = 0;
      forever begin
        @(negedge clk);
        if (t == 0) chk("stall_on_present", {31'd0, cpu_stall}, {31'd0, !h});
        if (!cpu_stall) break;
        if (t > 60) begin
          flag_fail("accept_timeout", {2'b00, a});
          break;
        end
        @(posedge clk);
        #1;
        t++;
        flush = (i == 0 && opt_flush_refill && t == 2);
      end
      @(posedge clk);
      #1;
      flush = 1'b0;
    end
    cpu_req = 1'b0;
    t = 0;
    while ((exp_word.size() > 0 || exp_mem.size() > 0) && t < 100) begin
      @(posedge clk);
      t++;
    end
    if (t >= 100) flag_fail("drain_timeout", exp_word.size() + exp_mem.size());
    @(posedge clk);
    #1;
    opt_hold         = 0;
    opt_flush_refill = 1'b0;
    opt_flush_idle   = 1'b0;
  endtask

  task automatic chk_counters(input string name);
`ifdef ICACHE_PERF_CNT_EN
    chk({name, "_hit_cnt"}, hit_cnt, tot_hits);
    chk({name, "_miss_cnt"}, miss_cnt, tot_miss);
`else
    chk({name, "_hit_cnt"}, hit_cnt, 32'd0);
    chk({name, "_miss_cnt"}, miss_cnt, 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    model_clear();
    in_reset = 1'b1;
    @(negedge clk);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_cpu_valid", {31'd0, cpu_valid}, 32'd0);
    chk("rst_cpu_inst", cpu_inst, 32'd0);
    chk("rst_cpu_stall", {31'd0, cpu_stall}, 32'd0);
    chk("rst_hit_cnt", hit_cnt, 32'd0);
    chk("rst_miss_cnt", miss_cnt, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_reset = 1'b0;

    // Cold miss at 0x008 then the rest of the line back-to-back.
    seq = '{30'h008, 30'h009, 30'h00A, 30'h00B};
    run();
    chk("cold_miss_latency", run_first_valid - run_start, 32'd8);
    chk("line_last_valid", run_last_valid - run_start, 32'd11);
    chk("cold_miss_grants", run_grants, 32'd4);
`ifdef ICACHE_PERF_CNT_EN
    chk("s2_hit_cnt", hit_cnt, 32'd4);
    chk("s2_miss_cnt", miss_cnt, 32'd1);
`endif
    chk_counters("after_line");

    // Conflict in set 0.
    seq = '{30'h000, 30'h100, 30'h000};
    run();
    chk("conflict_grants", run_grants, 32'd12);

    // Flush in IDLE alongside a hit: hit still served, then everything misses.
    opt_flush_idle = 1'b1;
    seq = '{30'h009, 30'h000};
    run();
    chk("idle_flush_grants", run_grants, 32'd4);

    // Grant withheld three cycles on the first word.
    opt_hold = 3;
    seq = '{30'h008};
    run();
    chk("bp_cycles", bp_cycles, 32'd3);
    chk("bp_latency", run_first_valid - run_start, 32'd11);

    // Flush during the second REFILL cycle.
    opt_flush_refill = 1'b1;
    seq = '{30'h030};
    run();
    chk("flush_refill_latency", run_first_valid - run_start, 32'd15);
    chk("flush_refill_grants", run_grants, 32'd8);
    seq = '{30'h030, 30'h008};
    run();
    chk("post_flush_grants", run_grants, 32'd4);
    chk_counters("after_flush");

    // Reset in the middle of a refill.
    in_reset = 1'b1;
    cpu_req  = 1'b1;
    cpu_addr = 30'h020;
    @(negedge clk);
    chk("rst_test_stall", {31'd0, cpu_stall}, 32'd1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("mid_refill_mem_req", {31'd0, mem_req}, 32'd1);
    @(posedge clk);
    #1;
    rst_n   = 1'b0;
    cpu_req = 1'b0;
    #1;
    chk("midrst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("midrst_cpu_valid", {31'd0, cpu_valid}, 32'd0);
    chk("midrst_cpu_inst", cpu_inst, 32'd0);
    chk("midrst_hit_cnt", hit_cnt, 32'd0);
    chk("midrst_miss_cnt", miss_cnt, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
    tot_hits = 0;
    tot_miss = 0;
    exp_mem.delete();
    exp_word.delete();
    exp_cyc.delete();
    repeat (3) @(posedge clk);
    #1;
    in_reset = 1'b0;

    seq = '{30'h020, 30'h030};
    run();
    chk("post_reset_grants", run_grants, 32'd8);
    chk_counters("after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
